// File: rtl/seg_scan_hex.sv
// seg_scan_hex: 8-digit common-anode hex display scanner with per-frame snapshot
//   clk, rst_n      : clock, asynchronous active-low reset
//   en              : 1 = scan, 0 = display dark
//   data, dp_en     : word (nibble i -> digit i) and decimal-point mask, snapshotted per frame
//   blank_lz        : suppress leading zeros (sampled live each tick)
//   an, seg, dp     : active-low registered drives, seg = {a,b,c,d,e,f,g}
//   frame_tick      : one-cycle pulse in the cycle a new frame snapshot is taken
module seg_scan_hex #(
   parameter int SCAN_DIV = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [31:0] data,
   input  logic [7:0]  dp_en,
   input  logic        blank_lz,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_tick
);
   localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);
   localparam logic [0:0] OFF = 1'b0;
   localparam logic [0:0] SCAN = 1'b1;

   logic [PW-1:0] cnt;
   logic [0:0]    state;
   logic [2:0]    idx;
   logic [31:0]   snap_data;
   logic [7:0]    snap_dp;
   logic          tick;
   logic          wrap;
   logic [2:0]    n_idx;
   logic [31:0]   n_data;
   logic [7:0]    n_dp;
   logic [3:0]    nib;
   logic          blank;

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: glyph = 7'b0000001;
         4'h1: glyph = 7'b1001111;
         4'h2: glyph = 7'b0010010;
         4'h3: glyph = 7'b0000110;
         4'h4: glyph = 7'b1001100;
         4'h5: glyph = 7'b0100100;
         4'h6: glyph = 7'b0100000;
         4'h7: glyph = 7'b0001111;
         4'h8: glyph = 7'b0000000;
         4'h9: glyph = 7'b0000100;
         4'hA: glyph = 7'b0001000;
         4'hB: glyph = 7'b1100000;
         4'hC: glyph = 7'b0110001;
         4'hD: glyph = 7'b1000010;
         4'hE: glyph = 7'b0110000;
         default: glyph = 7'b0111000;
      endcase
   endfunction

   assign tick = en && cnt == LAST;
   // A frame starts on the first tick out of OFF or on the tick leaving digit 7.
   assign wrap = tick && (state == OFF || idx == 3'd7);
   // With SCAN_DIV=1 the counter compare is always true, so gate the pulse during reset.
   assign frame_tick = rst_n && wrap;
   // Outputs are driven from the values idx/snap take on this edge, not the current ones.
   assign n_idx  = wrap ? 3'd0 : idx + 3'd1;
   assign n_data = wrap ? data : snap_data;
   assign n_dp   = wrap ? dp_en : snap_dp;
   assign nib    = n_data[{n_idx, 2'b00} +: 4];
   assign blank  = blank_lz && n_idx != 3'd0 && (n_data >> {n_idx, 2'b00}) == 32'd0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         state     <= OFF;
         idx       <= 3'd0;
         snap_data <= 32'd0;
         snap_dp   <= 8'd0;
         an        <= 8'hFF;
         seg       <= 7'h7F;
         dp        <= 1'b1;
      end else if (!en) begin
         cnt   <= '0;
         state <= OFF;
         idx   <= 3'd0;
         an    <= 8'hFF;
         seg   <= 7'h7F;
         dp    <= 1'b1;
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;
         if (tick) begin
            state     <= SCAN;
            idx       <= n_idx;
            snap_data <= n_data;
            snap_dp   <= n_dp;
            an        <= blank ? 8'hFF : ~(8'd1 << n_idx);
            seg       <= blank ? 7'h7F : glyph(nib);
            dp        <= blank | ~n_dp[n_idx];
         end
      end
   end
endmodule
